// File: rtl/tmr_regs_pkg.sv
// Timer register map, CON field positions and APB front-end FSM states.
// Shared by the address decoder, the APB slave and its bench.
package tmr_regs_pkg;

    localparam int unsigned TMR_CON_OFS = 32'h0;
    localparam int unsigned TMR_PRD_OFS = 32'h4;
    localparam int unsigned TMR_CNT_OFS = 32'h8;

    localparam int CON_MODE_LSB = 0;
    localparam int CON_MODE_MSB = 1;
    localparam int CON_SSEL_LSB = 2;
    localparam int CON_SSEL_MSB = 3;
    localparam int CON_DSEL_LSB = 4;
    localparam int CON_DSEL_MSB = 7;
    localparam int CON_PND_BIT  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WSTB,
        ST_WHOLD,
        ST_RCAP,
        ST_DONE
    } tmr_st_e;

endpackage

// File: rtl/tmr_apb_slv_if.sv
// APB3 bus bundle between a master and the timer front-end.
// Ports: psel/penable/pwrite/paddr/pwdata from master; prdata/pready/pslverr back.
interface tmr_apb_slv_if #(
    parameter int ADDR_W = 12
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/tmr_addr_dec.sv
// Combinational decode of an APB byte address onto the timer registers.
// Ports: i_paddr in; o_sel_con/o_sel_prd/o_sel_cnt one-hot selects, o_err otherwise.
module tmr_addr_dec #(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] i_paddr,
    output logic              o_sel_con,
    output logic              o_sel_prd,
    output logic              o_sel_cnt,
    output logic              o_err
);
    import tmr_regs_pkg::*;

    // Full-width compare: misaligned and aliased addresses fall into o_err.
    assign o_sel_con = (i_paddr == ADDR_W'(TMR_CON_OFS));
    assign o_sel_prd = (i_paddr == ADDR_W'(TMR_PRD_OFS));
    assign o_sel_cnt = (i_paddr == ADDR_W'(TMR_CNT_OFS));
    assign o_err     = ~(o_sel_con | o_sel_prd | o_sel_cnt);

endmodule

// File: rtl/tmr_apb_slv.sv
// APB3 slave front-end for the 16-bit timer: write strobes, held write data, reads.
// Ports: icb_clk, sys_rstn, apb (slave), tmr_*_wr strobes, icb_wdat, tmr_* read values.
module tmr_apb_slv #(
    parameter int ADDR_W  = 12,
    parameter int WR_HOLD = 2
) (
    input  logic                icb_clk,
    input  logic                sys_rstn,
    tmr_apb_slv_if.slave        apb,
    output logic                tmr_con_wr,
    output logic                tmr_prd_wr,
    output logic                tmr_cnt_wr,
    output logic [15:0]         icb_wdat,
    input  logic [15:0]         tmr_con,
    input  logic [15:0]         tmr_prd,
    input  logic [15:0]         tmr_cnt
);
    import tmr_regs_pkg::*;

    tmr_st_e     r_state;
    tmr_st_e     w_nxt;
    logic [2:0]  r_sel;
    logic        r_err;
    logic [15:0] r_wdat;
    logic [31:0] r_prdata;
    logic [3:0]  r_hold;

    logic        w_setup;
    logic        w_sel_con;
    logic        w_sel_prd;
    logic        w_sel_cnt;
    logic        w_err;
    logic [15:0] w_rd;
    logic        w_stb;
    logic        w_unused;

    assign w_unused = ^apb.pwdata[31:16];
    assign w_setup  = apb.psel & ~apb.penable;

    tmr_addr_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .i_paddr   (apb.paddr),
        .o_sel_con (w_sel_con),
        .o_sel_prd (w_sel_prd),
        .o_sel_cnt (w_sel_cnt),
        .o_err     (w_err)
    );

    always_ff @(posedge icb_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Outputs decode only from flops, so APB inputs never reach them directly.
    always_comb begin
        w_nxt       = r_state;
        w_stb       = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    if (w_err) begin
                        w_nxt = ST_DONE;
                    end else if (apb.pwrite) begin
                        w_nxt = ST_WSTB;
                    end else begin
                        w_nxt = ST_RCAP;
                    end
                end
            end
            ST_WSTB: begin
                w_stb = 1'b1;
                if (!apb.psel) begin
                    w_nxt = ST_IDLE;
                end else if (WR_HOLD == 0) begin
                    w_nxt = ST_DONE;
                end else begin
                    w_nxt = ST_WHOLD;
                end
            end
            ST_WHOLD: begin
                if (!apb.psel) begin
                    w_nxt = ST_IDLE;
                end else if (r_hold == 4'd1) begin
                    w_nxt = ST_DONE;
                end
            end
            ST_RCAP: begin
                w_nxt = apb.psel ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                apb.pready  = 1'b1;
                apb.pslverr = r_err;
                w_nxt       = ST_IDLE;
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    assign tmr_con_wr = w_stb & r_sel[0];
    assign tmr_prd_wr = w_stb & r_sel[1];
    assign tmr_cnt_wr = w_stb & r_sel[2];
    assign icb_wdat   = r_wdat;
    assign apb.prdata = r_prdata;

    always_comb begin
        w_rd = 16'd0;
        unique case (1'b1)
            r_sel[0]: w_rd = tmr_con;
            r_sel[1]: w_rd = tmr_prd;
            r_sel[2]: w_rd = tmr_cnt;
            default:  w_rd = 16'd0;
        endcase
    end

    // Write data lands on icb_wdat at the setup edge, so it is
    // already valid in the strobe cycle that follows.
    always_ff @(posedge icb_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_sel    <= 3'd0;
            r_err    <= 1'b0;
            r_wdat   <= 16'd0;
            r_prdata <= 32'd0;
            r_hold   <= 4'd0;
        end else begin
            if (r_state == ST_IDLE && w_setup) begin
                r_sel <= {w_sel_cnt, w_sel_prd, w_sel_con};
                r_err <= w_err;
                if (w_err) begin
                    r_prdata <= 32'd0;
                end else if (apb.pwrite) begin
                    r_wdat <= apb.pwdata[15:0];
                end
            end
            if (r_state == ST_WSTB) begin
                r_hold <= 4'(WR_HOLD);
            end
            if (r_state == ST_WHOLD) begin
                r_hold <= r_hold - 4'd1;
            end
            if (r_state == ST_RCAP && apb.psel) begin
                r_prdata <= {16'd0, w_rd};
            end
            if (r_state == ST_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
